tmp_readout: RTL and testbench
==============================

# tmp_readout

Readout block for the temperature-sensor front end. It consumes the phase strobes and pump controls produced by the sensor sequencer, and accumulates one conversion frame between consecutive OUTPUT phases. It then emits a signed net-pump code plus a comparator duty count to the digital back end over a valid/ready handshake. It sits between the sequencer outputs and the register/readout logic, in the sequencer's `clk` domain.

## Interface
- `CNT_W`, 10: width of the src/snk/duty counters. `code` is `CNT_W+1` bits.
- `FRAME_MAX`, 1023: timeout in cycles for a frame that never closes.
- `SYNC_STAGES`, 2: synchronizer depth for `src`, `snk`, `cmp`.

- `clk`  in  1  sequencer clock.
- `reset`  in  1  asynchronous, active-high.
- `pa`, `pb`, `pc`, `pd`  in  1 each  sequencer capacitor phase strobes, registered in the `clk` domain.
- `pi1`  in  1  big-diode phase strobe, registered in the `clk` domain.
- `src`, `snk`  in  1 each  pump source/sink enables. Combinational from the comparator, so treated as asynchronous.
- `cmp`  in  1  comparator output, asynchronous.
- `code_ready`  in  1  downstream accepts the result.
- `code`  out  `CNT_W+1`  signed, equal to `src_cnt − snk_cnt`.
- `duty`  out  `CNT_W`  cycles with `cmp=1` while `pi1=1`.
- `code_valid`  out  1  result held.
- `overrun`  out  1  sticky: a frame closed while the previous result was unconsumed.
- `timeout`  out  1  one-cycle pulse when a frame exceeds `FRAME_MAX`.

## Operation
- `out_ph = pa & pb & pc & pd`. The phase strobes are delayed by `SYNC_STAGES` so they stay aligned with the synchronized `src`/`snk`/`cmp`.
- Frame boundary: the registered rising edge of the delayed `out_ph`.
- States:
  - IDLE: counters cleared. On a boundary → ACCUM.
  - ACCUM: each cycle, count as follows.
    - `src_s=1` → `src_cnt+1`.
    - `snk_s=1` → `snk_cnt+1`.
    - `pi1_d & cmp_s` → `duty+1`.
    - `src_s` and `snk_s` both high in one cycle: both counters increment.
    - All counters saturate at `2^CNT_W−1` and never wrap.
    - `frame_cnt` increments every cycle.
  - ACCUM on a boundary:
    - Latch `code = src_cnt − snk_cnt` (zero-extended operands, `CNT_W+1`-bit two's-complement result) and `duty` into the output register.
    - Clear the counters, including the current-cycle increment, which is discarded.
    - Stay in ACCUM.
  - ACCUM with `frame_cnt == FRAME_MAX` → pulse `timeout`, clear counters, go to IDLE. No result is produced.
- Output register (one entry):
  - `code_valid` rises on latch and falls on the cycle after `code_valid & code_ready`.
  - `code`/`duty` are stable while `code_valid=1`.
- Latch while `code_valid & !code_ready`: the new result overwrites the register, `code_valid` stays 1, `overrun` is set.
- Latch in the same cycle as a handshake: the new result is loaded, `code_valid` stays 1, `overrun` is not set.
- `overrun` clears only on `reset`.
- Reset (async, any state): state=IDLE, all counters 0, `code`=0, `duty`=0, `code_valid`=0, `overrun`=0, `timeout`=0, synchronizer and delay flops 0.

## Timing
- Input → counter effect latency: `SYNC_STAGES`+1 cycles.
- Boundary-edge detect at cycle t (the internal delayed strobe) → `code_valid=1` and the new `code` visible at t+1.
- Handshake completes on the rising clk edge where `code_valid & code_ready`. `code_ready` may be high before `code_valid`.
- `timeout` is high for exactly one cycle, at `frame_cnt == FRAME_MAX`.
- A second boundary with no cycles between produces `code`=0, `duty`=0.

## Structure
- Package `tmp_pkg`:
  - state enum `{IDLE, ACCUM}`.
  - `CNT_W` default.
  - `code_t` typedef (signed, `CNT_W+1` bits).
- Sub-module `tmp_sync`: parameterised `SYNC_STAGES` flop chain with async reset. Instantiated for `src`, `snk`, `cmp` and for the phase-strobe delay line.

## Test plan
- Reset mid-ACCUM with 5 src pulses counted → all outputs 0, state IDLE, next boundary only opens a frame with no `code_valid`.
- Open frame, 37 cycles `src`, 12 cycles `snk`, boundary, `code_ready=1` → `code`=+25, one-cycle `code_valid`.
- Frame with 3 src, 40 snk → `code`=−37 (`0x7DB` at `CNT_W`=10).
- 20 cycles `pi1=1` with `cmp=1` on 8 of them → `duty`=8. `cmp` high outside `pi1` is not counted.
- `code_ready=0`, two frames closed (codes +4, then −2) → `code`=−2, `code_valid` held, `overrun`=1 until reset.
- 1100 `src` cycles with no boundary at `FRAME_MAX`=1023 → `timeout` pulse at frame cycle 1023, `src_cnt` saturates at 1023 and does not wrap, no `code_valid`, state IDLE.

Source files
------------

// File: rtl/tmp_pkg.sv
// Shared types and defaults for the temperature-sensor readout block.
package tmp_pkg;

    localparam int unsigned CNT_W_DFLT = 10;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    typedef logic signed [CNT_W_DFLT:0] code_t;

endpackage

// File: rtl/tmp_sync.sv
// Parameterised flop chain: synchronizer for async inputs and matching delay line.
module tmp_sync #(
    parameter int unsigned STAGES = 2,
    parameter int unsigned WIDTH  = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_chain [STAGES];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                r_chain[i] <= '0;
            end
        end else begin
            r_chain[0] <= i_d;
            for (int i = 1; i < int'(STAGES); i++) begin
                r_chain[i] <= r_chain[i-1];
            end
        end
    end

    assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/tmp_readout.sv
// Accumulates pump src/snk counts and comparator duty between OUTPUT phases
// and presents the result over a one-entry valid/ready output register.
module tmp_readout
    import tmp_pkg::*;
#(
    parameter int unsigned CNT_W       = CNT_W_DFLT,
    parameter int unsigned FRAME_MAX   = 1023,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_pa,
    input  logic             i_pb,
    input  logic             i_pc,
    input  logic             i_pd,
    input  logic             i_pi1,
    input  logic             i_src,
    input  logic             i_snk,
    input  logic             i_cmp,
    input  logic             i_code_ready,
    output logic [CNT_W:0]   o_code,
    output logic [CNT_W-1:0] o_duty,
    output logic             o_code_valid,
    output logic             o_overrun,
    output logic             o_timeout
);

    localparam int unsigned     FRM_W   = $clog2(FRAME_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [FRM_W-1:0] FRM_END = FRM_W'(FRAME_MAX);

    logic [2:0]       w_in_s;
    logic [1:0]       w_ph_d;
    logic             w_src_s;
    logic             w_snk_s;
    logic             w_cmp_s;
    logic             w_out_ph_d;
    logic             w_pi1_d;
    logic             w_boundary;
    logic [CNT_W:0]   w_code;

    state_t           r_state;
    logic             r_out_ph_q;
    logic [CNT_W-1:0] r_src_cnt;
    logic [CNT_W-1:0] r_snk_cnt;
    logic [CNT_W-1:0] r_duty_cnt;
    logic [FRM_W-1:0] r_frame_cnt;
    logic [CNT_W:0]   r_code;
    logic [CNT_W-1:0] r_duty;
    logic             r_code_valid;
    logic             r_overrun;
    logic             r_timeout;

    tmp_sync #(.STAGES(SYNC_STAGES), .WIDTH(3)) u_sync_in (
        .clk   (clk),
        .reset (reset),
        .i_d   ({i_src, i_snk, i_cmp}),
        .o_q   (w_in_s)
    );

    // Phase strobes are already clean; delay them to line up with the synchronized inputs.
    tmp_sync #(.STAGES(SYNC_STAGES), .WIDTH(2)) u_ph_dly (
        .clk   (clk),
        .reset (reset),
        .i_d   ({i_pa & i_pb & i_pc & i_pd, i_pi1}),
        .o_q   (w_ph_d)
    );

    assign w_src_s    = w_in_s[2];
    assign w_snk_s    = w_in_s[1];
    assign w_cmp_s    = w_in_s[0];
    assign w_out_ph_d = w_ph_d[1];
    assign w_pi1_d    = w_ph_d[0];
    assign w_boundary = w_out_ph_d & ~r_out_ph_q;
    assign w_code     = {1'b0, r_src_cnt} - {1'b0, r_snk_cnt};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_out_ph_q   <= 1'b0;
            r_src_cnt    <= '0;
            r_snk_cnt    <= '0;
            r_duty_cnt   <= '0;
            r_frame_cnt  <= '0;
            r_code       <= '0;
            r_duty       <= '0;
            r_code_valid <= 1'b0;
            r_overrun    <= 1'b0;
            r_timeout    <= 1'b0;
        end else begin
            r_out_ph_q <= w_out_ph_d;
            r_timeout  <= 1'b0;
            if (r_code_valid && i_code_ready) begin
                r_code_valid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    r_src_cnt   <= '0;
                    r_snk_cnt   <= '0;
                    r_duty_cnt  <= '0;
                    r_frame_cnt <= '0;
                    if (w_boundary) begin
                        r_state <= ACCUM;
                    end
                end
                ACCUM: begin
                    if (w_boundary) begin
                        // Close the frame; this cycle's increments are dropped.
                        r_code       <= w_code;
                        r_duty       <= r_duty_cnt;
                        r_code_valid <= 1'b1;
                        if (r_code_valid && !i_code_ready) begin
                            r_overrun <= 1'b1;
                        end
                        r_src_cnt   <= '0;
                        r_snk_cnt   <= '0;
                        r_duty_cnt  <= '0;
                        r_frame_cnt <= '0;
                    end else if (r_frame_cnt == FRM_END) begin
                        r_timeout   <= 1'b1;
                        r_src_cnt   <= '0;
                        r_snk_cnt   <= '0;
                        r_duty_cnt  <= '0;
                        r_frame_cnt <= '0;
                        r_state     <= IDLE;
                    end else begin
                        if (w_src_s && r_src_cnt != CNT_MAX) begin
                            r_src_cnt <= r_src_cnt + CNT_W'(1);
                        end
                        if (w_snk_s && r_snk_cnt != CNT_MAX) begin
                            r_snk_cnt <= r_snk_cnt + CNT_W'(1);
                        end
                        if (w_pi1_d && w_cmp_s && r_duty_cnt != CNT_MAX) begin
                            r_duty_cnt <= r_duty_cnt + CNT_W'(1);
                        end
                        r_frame_cnt <= r_frame_cnt + FRM_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_code       = r_code;
    assign o_duty       = r_duty;
    assign o_code_valid = r_code_valid;
    assign o_overrun    = r_overrun;
    assign o_timeout    = r_timeout;

endmodule

// File: tb/tb_tmp_readout.sv
// Scoreboard bench for tmp_readout: directed frames push expected results, a monitor checks handshakes.
module tb_tmp_readout;
    import tmp_pkg::*;

    typedef struct packed {
        code_t      code;
        logic [9:0] duty;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_pa = 0, i_pb = 0, i_pc = 0, i_pd = 0, i_pi1 = 0;
    logic        i_src = 0, i_snk = 0, i_cmp = 0, i_code_ready = 0;
    logic [10:0] o_code;
    logic [9:0]  o_duty;
    logic        o_code_valid, o_overrun, o_timeout;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   to_count = 0;
    int   to_cyc   = -1;
    exp_t exp_q[$];

    tmp_readout #(.CNT_W(10), .FRAME_MAX(1023), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_pa         (i_pa),
        .i_pb         (i_pb),
        .i_pc         (i_pc),
        .i_pd         (i_pd),
        .i_pi1        (i_pi1),
        .i_src        (i_src),
        .i_snk        (i_snk),
        .i_cmp        (i_cmp),
        .i_code_ready (i_code_ready),
        .o_code       (o_code),
        .o_duty       (o_duty),
        .o_code_valid (o_code_valid),
        .o_overrun    (o_overrun),
        .o_timeout    (o_timeout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every accepted result must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && o_code_valid && i_code_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: got code 0x%0h duty %0d expected no result", o_code, o_duty);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("code", {21'b0, o_code}, {21'b0, e.code});
                check("duty", {22'b0, o_duty}, {22'b0, e.duty});
            end
        end
        if (o_timeout) begin
            to_count++;
            to_cyc = cyc;
        end
    end

    task automatic step(input logic s, input logic k, input logic p, input logic c, input logic [3:0] ph);
        i_src = s; i_snk = k; i_pi1 = p; i_cmp = c;
        {i_pa, i_pb, i_pc, i_pd} = ph;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n, input logic s, input logic k, input logic p, input logic c);
        for (int i = 0; i < n; i++) step(s, k, p, c, 4'h0);
    endtask

    task automatic boundary();
        step(0, 0, 0, 0, 4'hF);
    endtask

    task automatic push(input int code, input int duty);
        exp_t e;
        e.code = code_t'(code);
        e.duty = 10'(duty);
        exp_q.push_back(e);
    endtask

    task automatic do_reset(input string tag);
        step(0, 0, 0, 0, 4'h0);
        reset = 1'b1;
        #2;
        check({tag, "_code"},    {21'b0, o_code}, 32'h0);
        check({tag, "_duty"},    {22'b0, o_duty}, 32'h0);
        check({tag, "_valid"},   {31'b0, o_code_valid}, 32'h0);
        check({tag, "_overrun"}, {31'b0, o_overrun}, 32'h0);
        check({tag, "_timeout"}, {31'b0, o_timeout}, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int c0;
        int waited;
        reset = 1'b1;
        #2;
        check("por_code",  {21'b0, o_code}, 32'h0);
        check("por_valid", {31'b0, o_code_valid}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        i_code_ready = 1'b1;

        // Reset in the middle of a frame that has already counted 5 src pulses.
        boundary();
        run(5, 1, 0, 0, 0);
        run(3, 0, 0, 0, 0);
        do_reset("rst_mid");

        // After reset the first boundary only opens a frame.
        boundary();
        run(1, 0, 0, 0, 0);
        run(37, 1, 0, 0, 0);
        run(12, 0, 1, 0, 0);
        push(25, 0);
        boundary();
        run(4, 0, 0, 0, 0);
        check("one_cycle_valid", {31'b0, o_code_valid}, 32'h0);

        // Simultaneous src/snk and a partial phase pattern that is not a boundary.
        run(10, 1, 0, 0, 0);
        run(6, 1, 1, 0, 0);
        run(4, 0, 1, 0, 0);
        step(0, 0, 0, 0, 4'hE);
        run(2, 0, 0, 0, 0);
        push(6, 0);
        boundary();
        run(4, 0, 0, 0, 0);

        // Negative code: 3 - 40 = -37.
        run(3, 1, 0, 0, 0);
        run(40, 0, 1, 0, 0);
        push(-37, 0);
        boundary();
        run(4, 0, 0, 0, 0);

        // Duty: cmp counted only while pi1 is high.
        run(8, 0, 0, 1, 1);
        run(12, 0, 0, 1, 0);
        run(5, 0, 0, 0, 1);
        push(0, 8);
        boundary();

        // Back-to-back boundaries give an empty result.
        run(1, 0, 0, 0, 0);
        push(0, 0);
        boundary();
        run(4, 0, 0, 0, 0);

        // New result latched on the same edge the held one is accepted: no overrun.
        i_code_ready = 1'b0;
        run(3, 1, 0, 0, 0);
        push(3, 0);
        boundary();
        run(4, 0, 0, 0, 0);
        check("held_valid", {31'b0, o_code_valid}, 32'h1);
        run(2, 1, 0, 0, 0);
        push(2, 0);
        boundary();
        run(1, 0, 0, 0, 0);
        i_code_ready = 1'b1;
        run(1, 0, 0, 0, 0);
        check("coincide_code", {21'b0, o_code}, 32'h2);
        check("coincide_valid", {31'b0, o_code_valid}, 32'h1);
        run(4, 0, 0, 0, 0);
        check("coincide_overrun", {31'b0, o_overrun}, 32'h0);

        // Overrun: +4 overwritten by -2 while unconsumed.
        i_code_ready = 1'b0;
        run(4, 1, 0, 0, 0);
        boundary();
        run(2, 0, 0, 0, 0);
        run(2, 0, 1, 0, 0);
        push(-2, 0);
        boundary();
        run(3, 0, 0, 0, 0);
        check("ovr_code", {21'b0, o_code}, 32'h7FE);
        check("ovr_valid", {31'b0, o_code_valid}, 32'h1);
        check("ovr_flag", {31'b0, o_overrun}, 32'h1);
        i_code_ready = 1'b1;
        run(3, 0, 0, 0, 0);
        check("ovr_sticky", {31'b0, o_overrun}, 32'h1);
        check("ovr_drained", {31'b0, o_code_valid}, 32'h0);
        do_reset("rst_ovr");

        // Timeout: frame never closes.
        c0 = cyc;
        boundary();
        run(1100, 1, 0, 0, 0);
        check("timeout_pulses", to_count, 32'd1);
        check("timeout_cycle", to_cyc, 32'(c0 + 1027));
        check("timeout_no_valid", {31'b0, o_code_valid}, 32'h0);
        // Back in IDLE: next boundary only opens.
        run(2, 0, 0, 0, 0);
        boundary();
        run(1, 0, 0, 0, 0);
        push(0, 0);
        boundary();
        run(4, 0, 0, 0, 0);

        waited = 0;
        while (exp_q.size() != 0 && waited < 20) begin
            run(1, 0, 0, 0, 0);
            waited++;
        end
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
